// File: rtl/reg_file_sb.sv
// Register file with registered 2-read/1-write ports and a pending-write scoreboard.
// Define REG_FILE_BYPASS_EN to let a same-cycle writeback release a busy source.
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  localparam int NREGS   = 2 ** ADDR_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rd_req_in,
  input  logic [ADDR_W-1:0] rs1_addr_in,
  input  logic [ADDR_W-1:0] rs2_addr_in,
  output logic              rd_stall_out,
  output logic [XLEN-1:0]   rs1_out,
  output logic [XLEN-1:0]   rs2_out,
  output logic              rd_valid_out,
  input  logic              issue_en_in,
  input  logic [ADDR_W-1:0] issue_addr_in,
  input  logic              wr_en_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic [XLEN-1:0]   rd_data,
  output logic [NREGS-1:0]  busy_out
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic             wr_eff;
  logic             issue_eff;
  logic             wr_hit1;
  logic             wr_hit2;
  logic             hz1;
  logic             hz2;
  logic             accept;
  logic [XLEN-1:0]  rs1_next;
  logic [XLEN-1:0]  rs2_next;

  // Register 0 is hard-wired when ZERO_REG is set: writes and issues to it vanish.
  assign wr_eff    = wr_en_in && !(ZERO_REG && (rd_addr_in == '0));
  assign issue_eff = issue_en_in && !(ZERO_REG && (issue_addr_in == '0));

  assign wr_hit1 = wr_eff && (rd_addr_in == rs1_addr_in);
  assign wr_hit2 = wr_eff && (rd_addr_in == rs2_addr_in);

`ifdef REG_FILE_BYPASS_EN
  assign hz1 = busy[rs1_addr_in] && !wr_hit1;
  assign hz2 = busy[rs2_addr_in] && !wr_hit2;
`else
  assign hz1 = busy[rs1_addr_in];
  assign hz2 = busy[rs2_addr_in];
`endif

  // Read handshake: a request is accepted in a cycle where rd_req_in=1 and
  // rd_stall_out=0; the operands then appear on rs1_out/rs2_out together with
  // rd_valid_out=1 in the following cycle. While stalled, the requester holds
  // rd_req_in and both addresses stable.
  assign rd_stall_out = rd_req_in && (hz1 || hz2);
  assign accept       = rd_req_in && !rd_stall_out;

  // Write-first operand selection; register 0 overrides everything.
  always_comb begin
    rs1_next = mem[rs1_addr_in];
    if (wr_hit1) rs1_next = rd_data;
    if (ZERO_REG && (rs1_addr_in == '0)) rs1_next = '0;
  end

  always_comb begin
    rs2_next = mem[rs2_addr_in];
    if (wr_hit2) rs2_next = rd_data;
    if (ZERO_REG && (rs2_addr_in == '0)) rs2_next = '0;
  end

  // The new producer wins when issue and writeback hit the same register.
  always_comb begin
    busy_next = busy;
    if (wr_eff)    busy_next[rd_addr_in]    = 1'b0;
    if (issue_eff) busy_next[issue_addr_in] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_eff) begin
      mem[rd_addr_in] <= rd_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) busy <= '0;
    else         busy <= busy_next;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rs1_out      <= '0;
      rs2_out      <= '0;
      rd_valid_out <= 1'b0;
    end else begin
      rd_valid_out <= accept;
      if (accept) begin
        rs1_out <= rs1_next;
        rs2_out <= rs2_next;
      end
    end
  end

  assign busy_out = busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb; expectations follow REG_FILE_BYPASS_EN.
// A second instance with ZERO_REG=0 shares the stimulus and is checked only on x0.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        issue_en = 1'b0;
  logic [4:0]  issue_addr = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  logic        stall, valid, stall0, valid0;
  logic [31:0] rs1, rs2, rs1_0, rs2_0, busy, busy0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q [$];

  reg_file_sb #(.XLEN(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .clk_in(clk), .rst_in(rst_n), .rd_req_in(rd_req),
    .rs1_addr_in(rs1_addr), .rs2_addr_in(rs2_addr), .rd_stall_out(stall),
    .rs1_out(rs1), .rs2_out(rs2), .rd_valid_out(valid),
    .issue_en_in(issue_en), .issue_addr_in(issue_addr),
    .wr_en_in(wr_en), .rd_addr_in(wr_addr), .rd_data(wr_data), .busy_out(busy)
  );

  reg_file_sb #(.XLEN(32), .ADDR_W(5), .ZERO_REG(1'b0)) dut0 (
    .clk_in(clk), .rst_in(rst_n), .rd_req_in(rd_req),
    .rs1_addr_in(rs1_addr), .rs2_addr_in(rs2_addr), .rd_stall_out(stall0),
    .rs1_out(rs1_0), .rs2_out(rs2_0), .rd_valid_out(valid0),
    .issue_en_in(issue_en), .issue_addr_in(issue_addr),
    .wr_en_in(wr_en), .rd_addr_in(wr_addr), .rd_data(wr_data), .busy_out(busy0)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change on the falling edge
  task automatic idle();
    rd_req = 1'b0; issue_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(); idle();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h77;
    issue_en = 1'b1; issue_addr = 5'd6;
    cyc(); idle();
    rd_req = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd5;
    cyc();
    n_checks++;
    if (valid !== 1'b1 || rs1 !== 32'h77) begin
      n_fail++;
      $display("FAIL pre_reset_read: valid=%b rs1=%h, required valid=1 rs1=00000077", valid, rs1);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 32'h0 || valid !== 1'b0 || rs1 !== 32'h0 || rs2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%h valid=%b rs1=%h rs2=%h, required all zero", busy, valid, rs1, rs2);
    end
    cyc(); idle();
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_pulse: valid=%b, required 0", valid);
    end
    rd_req = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd6;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_cleared: stall=%b, required 0", stall);
    end
    cyc();
    n_checks++;
    if (valid !== 1'b1 || rs1 !== 32'h0 || rs2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_x5_zero: valid=%b rs1=%h rs2=%h, required 1 0 0", valid, rs1, rs2);
    end
    idle();
  endtask

  task automatic test_basic_read();
    cyc(); idle();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
    cyc(); idle();
    rd_req = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd0;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_stall: stall=%b, required 0", stall);
    end
    cyc();
    n_checks++;
    if (valid !== 1'b1 || rs1 !== 32'hDEADBEEF || rs2 !== 32'h0) begin
      n_fail++;
      $display("FAIL basic_read: valid=%b rs1=%h rs2=%h, required 1 deadbeef 0", valid, rs1, rs2);
    end
    idle();
    cyc();
    n_checks++;
    if (valid !== 1'b0 || rs1 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL basic_hold: valid=%b rs1=%h, required 0 deadbeef", valid, rs1);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    issue_en = 1'b1; issue_addr = 5'd0;
    cyc(); idle();
    n_checks++;
    if (busy[0] !== 1'b0 || busy0[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_busy: busy[0]=%b busy0[0]=%b, required 0 1", busy[0], busy0[0]);
    end
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    cyc(); idle();
    rd_req = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd0;
    cyc();
    n_checks++;
    if (valid !== 1'b1 || rs1 !== 32'h0 || rs2 !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_read_z1: valid=%b rs1=%h rs2=%h, required 1 0 0", valid, rs1, rs2);
    end
    n_checks++;
    if (valid0 !== 1'b1 || rs1_0 !== 32'h1234) begin
      n_fail++;
      $display("FAIL zero_read_z0: valid=%b rs1=%h, required 1 00001234", valid0, rs1_0);
    end
    idle();
  endtask

  task automatic test_stall();
    cyc(); idle();
    issue_en = 1'b1; issue_addr = 5'd7;
    cyc(); idle();
    rd_req = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd7;
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_checks++;
      if (stall !== 1'b1 || busy[7] !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: stall=%b busy[7]=%b, required 1 1", c, stall, busy[7]);
      end
      cyc();
    end
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    #1;
    n_checks++;
`ifdef REG_FILE_BYPASS_EN
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release_c4: stall=%b, required 0", stall);
    end
`else
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release_c4: stall=%b, required 1", stall);
    end
`endif
    cyc();
    wr_en = 1'b0;
`ifdef REG_FILE_BYPASS_EN
    n_checks++;
    if (valid !== 1'b1 || rs2 !== 32'h55) begin
      n_fail++;
      $display("FAIL stall_data_c5: valid=%b rs2=%h, required 1 00000055", valid, rs2);
    end
    idle();
`else
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_valid_c5: valid=%b, required 0", valid);
    end
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release_c5: stall=%b, required 0", stall);
    end
    cyc();
    n_checks++;
    if (valid !== 1'b1 || rs2 !== 32'h55) begin
      n_fail++;
      $display("FAIL stall_data_c6: valid=%b rs2=%h, required 1 00000055", valid, rs2);
    end
    idle();
`endif
  endtask

  task automatic test_issue_write_same();
    cyc(); idle();
    issue_en = 1'b1; issue_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5;
    cyc(); idle();
    n_checks++;
    if (busy[9] !== 1'b1 || dut.mem[9] !== 32'hA5) begin
      n_fail++;
      $display("FAIL same_addr_state: busy[9]=%b x9=%h, required 1 000000a5", busy[9], dut.mem[9]);
    end
    rd_req = 1'b1; rs1_addr = 5'd9; rs2_addr = 5'd0;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL same_addr_stall: stall=%b, required 1", stall);
    end
    cyc(); idle();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0;
    cyc(); idle();
  endtask

  task automatic test_write_first();
    cyc(); idle();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    rd_req = 1'b1; rs1_addr = 5'd4; rs2_addr = 5'd3;
    cyc(); idle();
    n_checks++;
    if (valid !== 1'b1 || rs1 !== 32'h44 || rs2 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_first: valid=%b rs1=%h rs2=%h, required 1 00000044 deadbeef", valid, rs1, rs2);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  a1 [3];
    logic [4:0]  a2 [3];
    logic [31:0] val [32];
    logic [63:0] exp;
    a1[0] = 5'd1; a2[0] = 5'd2;
    a1[1] = 5'd2; a2[1] = 5'd3;
    a1[2] = 5'd3; a2[2] = 5'd1;
    val[1] = 32'h11111111; val[2] = 32'h22222222; val[3] = 32'hDEADBEEF;
    cyc(); idle();
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = val[1];
    cyc();
    wr_addr = 5'd2; wr_data = val[2];
    cyc(); idle();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (valid !== 1'b1 || {rs1, rs2} !== exp) begin
          n_fail++;
          $display("FAIL b2b_read%0d: valid=%b data=%h, required 1 %h", k, valid, {rs1, rs2}, exp);
        end
      end
      if (k < 3) begin
        rd_req = 1'b1; rs1_addr = a1[k]; rs2_addr = a2[k];
        exp_q.push_back({val[a1[k]], val[a2[k]]});
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_stall%0d: stall=%b, required 0", k, stall);
        end
      end else begin
        idle();
      end
      cyc();
    end
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: valid=%b, required 0", valid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    cyc();
    rst_n = 1'b1;
    test_reset();
    test_basic_read();
    test_zero_reg();
    test_stall();
    test_issue_write_same();
    test_write_first();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the core's 2-read/1-write register file, with registered reads and an integrated pending-write scoreboard. Sits between decode and the execute/writeback stages. Decode issues destination registers (marking them busy) and requests operand reads; writeback retires results (clearing busy). Reads of busy sources are stalled with a read-valid handshake, so the pipeline needs no separate hazard unit.

## Interface
- XLEN, 32: data width in bits.
- ADDR_W, 5: register address width; depth NREGS = 2**ADDR_W.
- ZERO_REG, 1: 1 = register 0 reads as zero, ignores writes, and is never marked busy; 0 = register 0 is an ordinary register.

- clk_in  input  1  sole clock; all state updates on its rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rd_req_in  input  1  operand read request.
- rs1_addr_in  input  ADDR_W  source 1 address.
- rs2_addr_in  input  ADDR_W  source 2 address.
- rd_stall_out  output  1  combinational; request not accepted this cycle.
- rs1_out  output  XLEN  registered source 1 data.
- rs2_out  output  XLEN  registered source 2 data.
- rd_valid_out  output  1  rs1_out/rs2_out hold data for a request accepted last cycle.
- issue_en_in  input  1  mark issue_addr_in busy (producer in flight).
- issue_addr_in  input  ADDR_W  destination being issued.
- wr_en_in  input  1  writeback strobe.
- rd_addr_in  input  ADDR_W  writeback address.
- rd_data  input  XLEN  writeback data.
- busy_out  output  NREGS  scoreboard vector; bit i set = register i pending.

## Operation
- Storage: NREGS x XLEN array plus NREGS busy bits.
- Write: on wr_en_in, mem[rd_addr_in] <= rd_data and busy[rd_addr_in] clears. Exception: when ZERO_REG=1 and rd_addr_in==0, the write is dropped.
- Issue: on issue_en_in, busy[issue_addr_in] sets. When ZERO_REG=1, issue to address 0 is ignored.
- Issue and write to the same address in the same cycle: data is written, and busy ends set (the new producer wins).
- Source hazard: hz_n = busy[rsn_addr_in] AND NOT (wr_en_in AND rd_addr_in==rsn_addr_in AND the write is not dropped).
- rd_stall_out = rd_req_in AND (hz_1 OR hz_2).
- Acceptance: a request is accepted when rd_req_in=1 and rd_stall_out=0. On acceptance, rs1_out/rs2_out load the operands and rd_valid_out is set to 1 for the next cycle.
- No acceptance: rd_valid_out drops to 0 and rs1_out/rs2_out hold their last values.
- Same-cycle write to a source address: the loaded value is rd_data (write-first). This path is independent of the bypass option.
- Address 0 with ZERO_REG=1: always reads 0.
- No state machine beyond the busy vector and the output registers; no ordering is imposed between the issue and writeback ports.

## Timing
- Read latency: 1 cycle from acceptance to rd_valid_out=1.
- Throughput: one read per cycle when no hazard.
- Stall: rd_stall_out is combinational from rd_req_in, the addresses, busy, and the write port. The requester holds rd_req_in and the addresses stable while stalled.
- Busy visibility: a busy bit set by issue in cycle N is visible on busy_out and in stall logic from cycle N+1. A busy bit cleared by write is handled as described under Configuration.
- Reset (rst_in=0, asynchronous): all registers 0, all busy bits 0, rs1_out=rs2_out=0, rd_valid_out=0. A request in flight at reset is discarded; rd_valid_out does not pulse after release.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - A writeback in cycle N to a busy source releases the hazard in cycle N (per hz_n above).
  - The accepted read returns rd_data.
- REG_FILE_BYPASS_EN undefined:
  - The write term is removed from hz_n, so stall depends on busy alone.
  - A source whose writeback lands in cycle N stalls in cycle N and is accepted in cycle N+1, reading from the array.
  - Costs one bubble per dependent read.

## Test plan
- Reset: hold rst_in=0 mid-request -> busy_out=0, rd_valid_out=0, rs1_out=rs2_out=0; after release, reading x5 returns 0.
- Basic read: write x3=0xDEADBEEF; next cycle rd_req_in with rs1=3, rs2=0 -> accepted, following cycle rs1_out=0xDEADBEEF, rs2_out=0, rd_valid_out=1.
- Zero register: with ZERO_REG=1, issue x0 and write x0=0x1234 -> busy_out[0]=0 and a read of x0 returns 0. With ZERO_REG=0, the read returns 0x1234.
- Scoreboard stall: issue x7, then request rs2=7 for 3 cycles -> rd_stall_out=1 for all 3. Write x7=0x55 in cycle 4 -> with BYPASS_EN, accepted in cycle 4 and rs2_out=0x55 in cycle 5; without BYPASS_EN, accepted in cycle 5 and data seen in cycle 6.
- Simultaneous issue and write to x9 (data 0xA5) -> x9 holds 0xA5, busy_out[9]=1, and a read of x9 stalls.
- Back-to-back reads: reads of x1, x2, x3 over 3 consecutive cycles with no hazards -> rd_valid_out=1 for 3 consecutive cycles with the correct data in order.
